// File: rtl/udm_frame_decoder.sv
// UART debug byte-stream decoder: strips SYNC/ESCAPE framing, decodes commands, issues single-word bus requests.
// Request rises one cycle after the last LEN/WDATA byte; a request is held until acked; bytes arriving in BUS are dropped with overrun_o.
// Optional: define UDM_NOINC_CMD_EN to enable 0x83/0x84 (write/read without address autoincrement).
module udm_frame_decoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  output logic        slave_rst_o,
  output logic        idcode_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_BUS
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ESC_BYTE  = 8'h5A;

  state_t      state_q, state_d;
  logic        esc_q, esc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        inc_q, inc_d;
  logic        req_q, req_d;
  logic        slave_rst_q, slave_rst_d;
  logic        idcode_q, idcode_d;
  logic        overrun_q, overrun_d;

  logic        is_sync;
  logic        is_esc;
  logic        is_data;
  logic [4:0]  byte_pos;

  assign is_sync  = rx_valid_i && !esc_q && (rx_data_i == SYNC_BYTE);
  assign is_esc   = rx_valid_i && !esc_q && (rx_data_i == ESC_BYTE);
  assign is_data  = rx_valid_i && !is_sync && !is_esc;
  assign byte_pos = {cnt_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    esc_d       = esc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    inc_d       = inc_q;
    req_d       = req_q;
    slave_rst_d = slave_rst_q;
    idcode_d    = 1'b0;
    overrun_d   = 1'b0;

    // Bus handshake; a read burst drops req for one cycle, then re-requests.
    if (state_q == S_BUS) begin
      if (req_q) begin
        if (bus_ack_i) begin
          req_d = 1'b0;
          if (inc_q) addr_d = addr_q + 32'd4;
          if (len_q <= 32'd4) begin
            state_d = S_IDLE;
          end else begin
            len_d = len_q - 32'd4;
            if (we_q) begin
              state_d = S_WDATA;
              cnt_d   = 2'd0;
            end
          end
        end
      end else begin
        req_d = 1'b1;
      end
      if (is_data) overrun_d = 1'b1;
    end

    if (is_esc) begin
      esc_d = 1'b1;
    end else if (is_data) begin
      esc_d = 1'b0;
      case (state_q)
        S_CMD: begin
          state_d = S_IDLE;
          case (rx_data_i)
            8'h00: idcode_d    = 1'b1;
            8'h80: slave_rst_d = 1'b1;
            8'hC0: slave_rst_d = 1'b0;
            8'h81: begin state_d = S_ADDR; cnt_d = 2'd0; we_d = 1'b1; inc_d = 1'b1; end
            8'h82: begin state_d = S_ADDR; cnt_d = 2'd0; we_d = 1'b0; inc_d = 1'b1; end
`ifdef UDM_NOINC_CMD_EN
            8'h83: begin state_d = S_ADDR; cnt_d = 2'd0; we_d = 1'b1; inc_d = 1'b0; end
            8'h84: begin state_d = S_ADDR; cnt_d = 2'd0; we_d = 1'b0; inc_d = 1'b0; end
`endif
            default: ;
          endcase
        end
        S_ADDR: begin
          addr_d[byte_pos +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LEN;
        end
        S_LEN: begin
          len_d[byte_pos +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if ({rx_data_i, len_q[23:0]} == 32'd0) begin
              state_d = S_IDLE;
            end else if (we_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_BUS;
              req_d   = 1'b1;
            end
          end
        end
        S_WDATA: begin
          wdata_d[byte_pos +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            req_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // SYNC wins over everything; a same-edge ack above still counts.
    if (is_sync) begin
      state_d = S_CMD;
      cnt_d   = 2'd0;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      esc_q       <= 1'b0;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      len_q       <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      inc_q       <= 1'b0;
      req_q       <= 1'b0;
      slave_rst_q <= 1'b0;
      idcode_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      esc_q       <= esc_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      inc_q       <= inc_d;
      req_q       <= req_d;
      slave_rst_q <= slave_rst_d;
      idcode_q    <= idcode_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign slave_rst_o = slave_rst_q;
  assign idcode_o    = idcode_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_udm_frame_decoder.sv
// Randomized bench for udm_frame_decoder: frames are escaped and sent byte-wise, bus transfers are compared with
// a transaction-level model derived from command, address and length.
module tb_udm_frame_decoder;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        slave_rst;
  logic        idcode;
  logic        overrun;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t obs_q[$];
  txn_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int idcode_cnt = 0;
  int overrun_cnt = 0;

  int   mon_age;
  bit   mon_last_acc;
  bit   mon_prev_req;
  bit   mon_prev_id;
  bit   mon_prev_ov;
  txn_t mon_prev_t;

  udm_frame_decoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_ack_i   (bus_ack),
    .slave_rst_o (slave_rst),
    .idcode_o    (idcode),
    .overrun_o   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus slave model and protocol monitor: acks after ack_delay cycles of request, records transfers.
  initial begin
    bus_ack = 1'b0;
    mon_age = 0;
    mon_last_acc = 1'b0;
    mon_prev_req = 1'b0;
    mon_prev_id = 1'b0;
    mon_prev_ov = 1'b0;
    mon_prev_t = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ack = 1'b0;
        mon_age = 0;
        mon_last_acc = 1'b0;
        mon_prev_req = 1'b0;
        mon_prev_id = 1'b0;
        mon_prev_ov = 1'b0;
      end else begin
        if (mon_last_acc) begin
          checks++;
          if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL req_gap: bus_req_o=%b the cycle after accept, required 0", bus_req);
          end
        end
        if (bus_req && mon_prev_req && !mon_last_acc) begin
          checks++;
          if ({bus_we, bus_addr, bus_wdata} !== mon_prev_t) begin
            failures++;
            $display("FAIL req_stable: we/addr/wdata=%b/%h/%h changed while pending, was %b/%h/%h",
                     bus_we, bus_addr, bus_wdata, mon_prev_t.we, mon_prev_t.addr, mon_prev_t.wdata);
          end
        end
        mon_prev_t = {bus_we, bus_addr, bus_wdata};
        mon_prev_req = bus_req;
        if (bus_req) begin
          bus_ack = (mon_age >= ack_delay);
          mon_age++;
        end else begin
          bus_ack = 1'b0;
          mon_age = 0;
        end
        mon_last_acc = bus_req && bus_ack;
        if (mon_last_acc) begin
          obs_q.push_back(mon_prev_t);
          mon_age = 0;
        end
        if (idcode) begin
          checks++;
          if (mon_prev_id !== 1'b0) begin
            failures++;
            $display("FAIL idcode_width: idcode_o high %0d consecutive cycles, required 1", 2);
          end else idcode_cnt++;
        end
        mon_prev_id = idcode;
        if (overrun) begin
          checks++;
          if (mon_prev_ov !== 1'b0) begin
            failures++;
            $display("FAIL overrun_width: overrun_o high %0d consecutive cycles, required 1", 2);
          end else overrun_cnt++;
        end
        mon_prev_ov = overrun;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int cmd_kind(input logic [7:0] c);
    case (c)
      8'h81: return 1;
      8'h82: return 2;
`ifdef UDM_NOINC_CMD_EN
      8'h83: return 1;
      8'h84: return 2;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic bit cmd_inc(input logic [7:0] c);
    return (c == 8'h81) || (c == 8'h82);
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 5))
      0: return 8'h55;
      1: return 8'h5A;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_raw(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (b == 8'h55 || b == 8'h5A) send_raw(8'h5A);
    send_raw(b);
  endtask

  task automatic rx_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    rx_idle(1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] len);
    send_raw(8'h55);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  // Sends one frame and fills exp_q with the transfers it should produce.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] len,
                          input int dly, input bit rnd_data, input logic [31:0] wd_fixed, output bit ok);
    int   kind;
    int   words;
    int   base;
    bit   okw;
    txn_t t;
    logic [31:0] wd;
    ack_delay = dly;
    kind  = cmd_kind(cmd);
    words = int'((len + 32'd3) >> 2);
    base  = obs_q.size();
    ok    = 1'b1;
    send_header(cmd, addr, len);
    if (kind == 0 || len == 32'd0) begin
      rx_idle(6);
    end else if (kind == 2) begin
      for (int w = 0; w < words; w++) begin
        t.we = 1'b0;
        t.addr = addr + (cmd_inc(cmd) ? 32'(4 * w) : 32'd0);
        t.wdata = '0;
        exp_q.push_back(t);
      end
      wait_obs(base + words, ok);
    end else begin
      for (int w = 0; w < words; w++) begin
        wd = rnd_data ? {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()} : wd_fixed;
        t.we = 1'b1;
        t.addr = addr + (cmd_inc(cmd) ? 32'(4 * w) : 32'd0);
        t.wdata = wd;
        exp_q.push_back(t);
        for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
        wait_obs(base + w + 1, okw);
        ok = ok & okw;
      end
    end
    rx_idle(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_req: bus_req_o=%b required 0", bus_req); end
    checks++;
    if ({bus_we, bus_addr, bus_wdata} !== 65'd0) begin
      failures++;
      $display("FAIL reset_bus: we/addr/wdata=%b/%h/%h required 0/0/0", bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if (slave_rst !== 1'b0) begin failures++; $display("FAIL reset_slave_rst: got %b required 0", slave_rst); end
    checks++;
    if ({idcode, overrun} !== 2'b00) begin failures++; $display("FAIL reset_pulses: idcode/overrun=%b required 00", {idcode, overrun}); end
    rst = 1'b0;
    rx_idle(2);
  endtask

  task automatic test_directed();
    logic [7:0]  cmds[4]  = '{8'h81, 8'h81, 8'h82, 8'h84};
    logic [31:0] addrs[4] = '{32'h0, 32'h8, 32'h10, 32'h10};
    logic [31:0] lens[4]  = '{32'd4, 32'd4, 32'd8, 32'd8};
    int          dlys[4]  = '{0, 1, 3, 2};
    logic [31:0] wds[4]   = '{32'h0000_33CC, 32'h0000_5A55, 32'h0, 32'h0};
    bit   ok;
    txn_t o;
    txn_t e;
    for (int v = 0; v < 4; v++) begin
      do_frame(cmds[v], addrs[v], lens[v], dlys[v], 1'b0, wds[v], ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL directed%0d_timeout: got %0d transfers, wanted %0d", v, obs_q.size(), exp_q.size()); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL directed%0d_count: got %0d transfers, required %0d", v, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
          failures++;
          $display("FAIL directed%0d_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   v, o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    int id0;
    logic [7:0] seq[6] = '{8'h55, 8'h81, 8'h00, 8'h00, 8'h55, 8'h00};
    id0 = idcode_cnt;
    for (int i = 0; i < 6; i++) send_raw(seq[i]);
    rx_idle(4);
    checks++;
    if (idcode_cnt - id0 !== 1) begin failures++; $display("FAIL abort_idcode: %0d pulses, required 1", idcode_cnt - id0); end
    checks++;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL abort_noreq: %0d transfers, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_slave_rst();
    send_raw(8'h55);
    send_raw(8'h80);
    rx_idle(2);
    checks++;
    if (slave_rst !== 1'b1) begin failures++; $display("FAIL slave_rst_set: got %b required 1", slave_rst); end
    send_raw(8'h55);
    send_raw(8'h00);
    rx_idle(2);
    checks++;
    if (slave_rst !== 1'b1) begin failures++; $display("FAIL slave_rst_hold: got %b required 1", slave_rst); end
    send_raw(8'h55);
    send_raw(8'hC0);
    rx_idle(2);
    checks++;
    if (slave_rst !== 1'b0) begin failures++; $display("FAIL slave_rst_clr: got %b required 0", slave_rst); end
  endtask

  task automatic test_overrun();
    int  ov0;
    bit  ok;
    ov0 = overrun_cnt;
    ack_delay = 8;
    send_header(8'h82, 32'h0000_0040, 32'd4);
    rx_idle(1);
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL req_latency: bus_req_o=%b one cycle after last LEN byte, required 1", bus_req); end
    send_raw(8'h11);
    rx_idle(2);
    checks++;
    if (overrun_cnt - ov0 !== 1) begin failures++; $display("FAIL overrun_pulse: %0d pulses, required 1", overrun_cnt - ov0); end
    wait_obs(1, ok);
    checks++;
    if (!ok || obs_q.size() !== 1) begin
      failures++;
      $display("FAIL overrun_txn_count: %0d transfers, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].we !== 1'b0 || obs_q[0].addr !== 32'h40) begin
        failures++;
        $display("FAIL overrun_txn: got we=%b addr=%h, required we=0 addr=00000040", obs_q[0].we, obs_q[0].addr);
      end
    end
    obs_q.delete();
    rx_idle(3);
  endtask

  task automatic test_sync_in_bus();
    int id0;
    ack_delay = 1000;
    send_header(8'h82, 32'h0000_0080, 32'd8);
    rx_idle(3);
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL sync_bus_pending: bus_req_o=%b required 1", bus_req); end
    send_raw(8'h55);
    rx_idle(1);
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL sync_bus_drop: bus_req_o=%b after SYNC, required 0", bus_req); end
    id0 = idcode_cnt;
    send_raw(8'h00);
    rx_idle(8);
    checks++;
    if (idcode_cnt - id0 !== 1) begin failures++; $display("FAIL sync_bus_cmd: %0d idcode pulses, required 1", idcode_cnt - id0); end
    checks++;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL sync_bus_noreq: %0d transfers, required 0", obs_q.size()); end
    obs_q.delete();
    ack_delay = 0;
  endtask

  task automatic test_rst_mid();
    bit ok;
    send_raw(8'h55);
    send_raw(8'h80);
    send_header(8'h81, 32'h0000_0100, 32'd4);
    rx_idle(1);
    // restart a frame and stop after two LEN bytes
    send_raw(8'h55);
    send_byte(8'h81);
    for (int i = 0; i < 4; i++) send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, slave_rst, idcode, overrun} !== 69'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: req=%b we=%b addr=%h wdata=%h slave_rst=%b, required all 0",
               bus_req, bus_we, bus_addr, bus_wdata, slave_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    // still IDLE: remaining LEN bytes and a would-be payload must be ignored
    for (int i = 0; i < 10; i++) send_byte(8'h81);
    rx_idle(10);
    checks++;
    if (obs_q.size() !== 0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: %0d transfers req=%b, required 0 and 0", obs_q.size(), bus_req);
    end
    obs_q.delete();
    exp_q.delete();
    do_frame(8'h81, 32'h0000_0200, 32'd4, 1, 1'b1, 32'h0, ok);
    checks++;
    if (!ok || obs_q.size() !== 1) begin
      failures++;
      $display("FAIL rst_mid_recover: %0d transfers, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL rst_mid_txn: got addr=%h wdata=%h, required addr=%h wdata=%h",
                 obs_q[0].addr, obs_q[0].wdata, exp_q[0].addr, exp_q[0].wdata);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] cmd_tab[6] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h81, 8'h13};
    bit   ok;
    txn_t o;
    txn_t e;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] len;
    for (int f = 0; f < 30; f++) begin
      cmd  = cmd_tab[$urandom_range(0, 5)];
      addr = $urandom;
      len  = 32'($urandom_range(0, 13));
      do_frame(cmd, addr, len, int'($urandom_range(0, 4)), 1'b1, 32'h0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand%0d_timeout: got %0d transfers, wanted %0d", f, obs_q.size(), exp_q.size()); end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: cmd=%h len=%0d got %0d transfers, required %0d", f, cmd, len, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
          failures++;
          $display("FAIL rand%0d_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   f, o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    test_reset();
    test_directed();
    test_abort();
    test_slave_rst();
    test_overrun();
    test_sync_in_bus();
    test_rst_mid();
    test_random();
    rx_idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
